// File: rtl/riio_bist_pkg.sv
// Shared FSM encoding and PRBS7 constants for the RIIO pad loopback BIST.
// Declarations only: no latency, no flow control.
package riio_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_DRAIN,
    ST_DONE
  } bist_state_e;

  localparam logic [6:0] PRBS7_SEED   = 7'h7F;
  localparam int         PRBS7_TAP_HI = 6;
  localparam int         PRBS7_TAP_LO = 5;

  // x^7 + x^6 + 1: shift left, feedback from the two top bits into bit 0
  function automatic logic [6:0] prbs7_next(input logic [6:0] state);
    return {state[5:0], state[PRBS7_TAP_HI] ^ state[PRBS7_TAP_LO]};
  endfunction

endpackage

// File: rtl/riio_prbs7_gen.sv
// PRBS7 source: bit_o is the MSB of the current LFSR state; load wins over step.
// Latency: state updates one edge after load_i/step_i; no backpressure.
module riio_prbs7_gen
  import riio_bist_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic step_i,
  output logic bit_o
);

  logic [6:0] r_lfsr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= PRBS7_SEED;
    end else if (load_i) begin
      r_lfsr <= PRBS7_SEED;
    end else if (step_i) begin
      r_lfsr <= prbs7_next(r_lfsr);
    end
  end

  assign bit_o = r_lfsr[PRBS7_TAP_HI];

endmodule

// File: rtl/riio_pad_loopback_tester.sv
// Pad loopback BIST: drives PRBS7 out of the pad, checks the returned stream after a set latency.
// Latency: done_o len+lat+1 cycles after an accepted start; start_i is ignored while busy or in DONE.
module riio_pad_loopback_tester
  import riio_bist_pkg::*;
#(
  parameter  int LEN_W   = 16,
  parameter  int ERR_W   = 16,
  parameter  int LAT_MAX = 7,
  localparam int LAT_W   = $clog2(LAT_MAX + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [LAT_W-1:0] lat_i,
  output logic             pad_out_o,
  output logic             pad_oe_o,
  input  logic             pad_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [LEN_W-1:0] first_err_idx_o
);

  bist_state_e r_state;
  bist_state_e w_state_nxt;

  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_tx_idx;
  logic [LEN_W-1:0]   r_rx_idx;
  logic [LEN_W-1:0]   r_first_err;
  logic [LAT_W-1:0]   r_lat;
  logic [LAT_W-1:0]   w_lat_clamp;
  logic [LAT_W-1:0]   w_tap;
  logic [ERR_W-1:0]   r_err_cnt;
  logic [ERR_W-1:0]   w_err_cnt_nxt;
  logic [LAT_MAX-1:0] r_exp_dat;
  logic [LAT_MAX-1:0] r_exp_vld;
  logic               r_pad_out;
  logic               r_pad_oe;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic               w_start;
  logic               w_cmp;
  logic               w_mismatch;
  logic               w_last_tx;
  logic               w_last_rx;
  logic               w_drive_nxt;
  logic               w_prbs_bit;

  // The LFSR sits at the seed whenever not driving, so the first bit is ready on the start edge.
  riio_prbs7_gen u_prbs (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (~w_drive_nxt),
    .step_i (w_drive_nxt),
    .bit_o  (w_prbs_bit)
  );

  always_comb begin
    w_lat_clamp = lat_i;
    if (lat_i == '0) begin
      w_lat_clamp = LAT_W'(1);
    end else if (int'(lat_i) > LAT_MAX) begin
      w_lat_clamp = LAT_W'(LAT_MAX);
    end
  end

  // r_pad_out/r_pad_oe act as stage 0 of the delay line, so stage index lat-1 is lat cycles old.
  assign w_start     = (r_state == ST_IDLE) && start_i;
  assign w_tap       = r_lat - LAT_W'(1);
  assign w_cmp       = r_exp_vld[w_tap];
  assign w_mismatch  = w_cmp && (pad_in_i != r_exp_dat[w_tap]);
  assign w_last_tx   = (r_tx_idx == r_len - LEN_W'(1));
  assign w_last_rx   = (r_rx_idx == r_len - LEN_W'(1));
  assign w_drive_nxt = (w_state_nxt == ST_DRIVE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = (len_i != '0) ? ST_DRIVE : ST_DONE;
        end
      end
      ST_DRIVE: begin
        if (w_last_tx) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_cmp && w_last_rx) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_err_cnt_nxt = r_err_cnt;
    if (w_mismatch && !(&r_err_cnt)) begin
      w_err_cnt_nxt = r_err_cnt + ERR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pad_out   <= 1'b0;
      r_pad_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_len       <= '0;
      r_lat       <= LAT_W'(1);
      r_tx_idx    <= '0;
      r_rx_idx    <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '1;
      r_exp_dat   <= '0;
      r_exp_vld   <= '0;
    end else begin
      r_pad_oe  <= w_drive_nxt;
      r_pad_out <= w_drive_nxt & w_prbs_bit;
      r_busy    <= (w_state_nxt == ST_DRIVE) || (w_state_nxt == ST_DRAIN);
      r_done    <= (w_state_nxt == ST_DONE);
      r_exp_dat <= {r_exp_dat[LAT_MAX-2:0], r_pad_out};
      r_exp_vld <= {r_exp_vld[LAT_MAX-2:0], r_pad_oe};
      if (w_start) begin
        r_len       <= len_i;
        r_lat       <= w_lat_clamp;
        r_tx_idx    <= '0;
        r_rx_idx    <= '0;
        r_err_cnt   <= '0;
        r_first_err <= '1;
        r_pass      <= (len_i == '0);
        r_exp_vld   <= '0;
      end else begin
        if (r_state == ST_DRIVE) begin
          r_tx_idx <= r_tx_idx + LEN_W'(1);
        end
        if (w_cmp) begin
          r_rx_idx <= r_rx_idx + LEN_W'(1);
        end
        r_err_cnt <= w_err_cnt_nxt;
        // A saturated counter never returns to zero, so zero still means "no error seen yet".
        if (w_mismatch && (r_err_cnt == '0)) begin
          r_first_err <= r_rx_idx;
        end
        if ((r_state == ST_DRAIN) && (w_state_nxt == ST_DONE)) begin
          r_pass <= (w_err_cnt_nxt == '0);
        end
      end
    end
  end

  assign pad_out_o       = r_pad_out;
  assign pad_oe_o        = r_pad_oe;
  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign pass_o          = r_pass;
  assign err_cnt_o       = r_err_cnt;
  assign first_err_idx_o = r_first_err;

endmodule
